// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: shared request type and constants for the write-port arbiter
package wb_arb_pkg;
  localparam int XLEN = 32;
  localparam logic [4:0] X0_ADDR = 5'd0;
  typedef struct packed {
    logic            is_fp;
    logic [4:0]      addr;
    logic [XLEN-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/wb_res_fifo.sv
// wb_res_fifo: in-order queue of long-latency results with per-entry kill bits
module wb_res_fifo
  import wb_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  wb_req_t    push_data,
  input  logic       pop,
  input  logic       kill_en,
  input  logic       kill_is_fp,
  input  logic [4:0] kill_addr,
  output logic       full,
  output logic       empty,
  output wb_req_t    head,
  output logic       head_killed
);
  localparam int AW = $clog2(DEPTH);
  wb_req_t mem [DEPTH];
  logic [DEPTH-1:0] dead;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic push_kill;
  assign push_kill = kill_en && push_data.is_fp == kill_is_fp && push_data.addr == kill_addr;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign head = mem[rd_ptr];
  assign head_killed = dead[rd_ptr];
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= push_data;
  // the push slot's kill bit overrides whatever the stale slot content matched
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      dead <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (kill_en && mem[i].is_fp == kill_is_fp && mem[i].addr == kill_addr) dead[i] <= 1'b1;
      if (push) begin
        dead[wr_ptr] <= push_kill;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
endmodule

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares RF write ports between WB and queued long-latency results
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wb_valid,
  input  logic            wb_is_fp,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,
  input  logic            llu_valid,
  output logic            llu_ready,
  input  logic            llu_is_fp,
  input  logic [4:0]      llu_addr,
  input  logic [XLEN-1:0] llu_data,
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic            frf_we,
  output logic [4:0]      frf_waddr,
  output logic [XLEN-1:0] frf_wdata,
  output logic            stall_req
);
  localparam int AGW = $clog2(STARVE_LIMIT + 1);
  wb_req_t head;
  logic full, empty, head_killed, int_busy, fp_busy, dead, live, pop, push, head_write;
  logic [AGW-1:0] age;
  wb_res_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .push_data('{is_fp: llu_is_fp, addr: llu_addr, data: llu_data}),
    .pop(pop),
    .kill_en(int_busy || fp_busy),
    .kill_is_fp(wb_is_fp),
    .kill_addr(wb_addr),
    .full(full),
    .empty(empty),
    .head(head),
    .head_killed(head_killed)
  );
  assign int_busy = rst && wb_valid && !wb_is_fp && wb_addr != X0_ADDR;
  assign fp_busy = rst && wb_valid && wb_is_fp;
  // killed heads and int x0 results leave the queue without touching a port
  assign dead = head_killed || (!head.is_fp && head.addr == X0_ADDR);
  assign live = !empty && !dead;
  assign pop = rst && !empty && (dead || (head.is_fp ? !fp_busy : !int_busy));
  assign head_write = pop && !dead;
  assign llu_ready = rst && !full;
  assign push = llu_valid && llu_ready;
  assign rf_we = int_busy || (head_write && !head.is_fp);
  assign rf_waddr = int_busy ? wb_addr : (rf_we ? head.addr : '0);
  assign rf_wdata = int_busy ? wb_data : (rf_we ? head.data : '0);
  assign frf_we = fp_busy || (head_write && head.is_fp);
  assign frf_waddr = fp_busy ? wb_addr : (frf_we ? head.addr : '0);
  assign frf_wdata = fp_busy ? wb_data : (frf_we ? head.data : '0);
  assign stall_req = rst && live && age == AGW'(STARVE_LIMIT);
  always_ff @(posedge clk or negedge rst)
    if (!rst) age <= '0;
    else if (pop || !live) age <= '0;
    else if (age != AGW'(STARVE_LIMIT)) age <= age + 1'b1;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed stimulus checked against a queue-level model every cycle
module tb_wb_port_arbiter;
  localparam int DEPTH = 4;
  localparam int LIMIT = 8;
  logic clk = 0, rst = 0;
  logic wb_valid = 0, wb_is_fp = 0, llu_valid = 0, llu_is_fp = 0;
  logic [4:0] wb_addr = 0, llu_addr = 0;
  logic [31:0] wb_data = 0, llu_data = 0;
  logic llu_ready, rf_we, frf_we, stall_req;
  logic [4:0] rf_waddr, frf_waddr;
  logic [31:0] rf_wdata, frf_wdata;
  int n_vec = 0, n_bad = 0, wr_seen = 0;
  logic [31:0] shadow_x [32];
  logic [31:0] shadow_f [32];

  typedef struct {
    logic        fp;
    logic [4:0]  a;
    logic [31:0] d;
    bit          k;
  } ent_t;
  ent_t q[$];
  int waited = 0;

  wb_port_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_is_fp(wb_is_fp), .wb_addr(wb_addr), .wb_data(wb_data),
    .llu_valid(llu_valid), .llu_ready(llu_ready), .llu_is_fp(llu_is_fp),
    .llu_addr(llu_addr), .llu_data(llu_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .frf_we(frf_we), .frf_waddr(frf_waddr), .frf_wdata(frf_wdata),
    .stall_req(stall_req)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // model: outputs from the queue contents and this cycle's inputs, then advance the queue
  always @(negedge clk) begin
    automatic logic iw = rst && wb_valid && !wb_is_fp && wb_addr != 0;
    automatic logic fw = rst && wb_valid && wb_is_fp;
    automatic logic e_rw = iw, e_fw = fw, e_pop = 0, h_live = 0, e_ready, e_stall, e_push;
    automatic logic [4:0] e_ra = iw ? wb_addr : 5'd0, e_fa = fw ? wb_addr : 5'd0;
    automatic logic [31:0] e_rd = iw ? wb_data : 0, e_fd = fw ? wb_data : 0;
    automatic ent_t h, n;
    if (rst && q.size() > 0) begin
      h = q[0];
      h_live = !(h.k || (!h.fp && h.a == 0));
      if (!h_live) e_pop = 1;
      else if (h.fp && !fw) begin e_fw = 1; e_fa = h.a; e_fd = h.d; e_pop = 1; end
      else if (!h.fp && !iw) begin e_rw = 1; e_ra = h.a; e_rd = h.d; e_pop = 1; end
    end
    e_ready = rst && q.size() < DEPTH;
    e_stall = h_live && waited >= LIMIT;
    e_push = e_ready && llu_valid;
    chk("rf_we", rf_we, e_rw);
    chk("frf_we", frf_we, e_fw);
    chk("llu_ready", llu_ready, e_ready);
    chk("stall_req", stall_req, e_stall);
    if (e_rw || !rst) begin chk("rf_waddr", rf_waddr, e_ra); chk("rf_wdata", rf_wdata, e_rd); end
    if (e_fw || !rst) begin chk("frf_waddr", frf_waddr, e_fa); chk("frf_wdata", frf_wdata, e_fd); end
    if (rf_we) begin shadow_x[rf_waddr] = rf_wdata; wr_seen++; end
    if (frf_we) begin shadow_f[frf_waddr] = frf_wdata; wr_seen++; end
    if (!rst) begin
      q.delete();
      waited = 0;
    end else begin
      if (e_pop) void'(q.pop_front());
      waited = (e_pop || !h_live) ? 0 : waited + 1;
      if (iw || fw)
        foreach (q[i]) if (q[i].fp == wb_is_fp && q[i].a == wb_addr) q[i].k = 1;
      if (e_push) begin
        n.fp = llu_is_fp; n.a = llu_addr; n.d = llu_data;
        n.k = (iw || fw) && llu_is_fp == wb_is_fp && llu_addr == wb_addr;
        q.push_back(n);
      end
    end
  end

  task automatic cyc(input logic r, wv, wfp, input logic [4:0] wa, input logic [31:0] wd,
                     input logic lv, lfp, input logic [4:0] la, input logic [31:0] ld);
    @(posedge clk);
    #1;
    rst = r; wb_valid = wv; wb_is_fp = wfp; wb_addr = wa; wb_data = wd;
    llu_valid = lv; llu_is_fp = lfp; llu_addr = la; llu_data = ld;
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int w0;
    for (int i = 0; i < 32; i++) begin shadow_x[i] = 0; shadow_f[i] = 0; end
    cyc(0, 1, 0, 7, 32'h11, 1, 0, 5, 32'h1);
    chk("rst_rf_we", rf_we, 0);
    chk("rst_ready", llu_ready, 0);
    idle();
    // port conflict: x5 waits behind WB x7, then shares the cycle with WB f2
    cyc(1, 0, 0, 0, 0, 1, 0, 5, 32'hDEAD_BEEF);
    chk("no_bypass", rf_we, 0);
    repeat (3) begin
      cyc(1, 1, 0, 7, 32'h77, 0, 0, 0, 0);
      chk("wb_x7_addr", rf_waddr, 7);
    end
    cyc(1, 1, 1, 2, 32'h22, 0, 0, 0, 0);
    chk("conf_rf_we", rf_we, 1);
    chk("conf_rf_waddr", rf_waddr, 5);
    chk("conf_rf_wdata", rf_wdata, 32'hDEAD_BEEF);
    chk("conf_frf_waddr", frf_waddr, 2);
    idle();
    // starvation
    cyc(1, 1, 0, 7, 32'h70, 1, 0, 5, 32'h55);
    for (int i = 1; i <= 9; i++) begin
      cyc(1, 1, 0, 7, 32'h70 + i, 0, 0, 0, 0);
      if (i == 8) chk("stall_c8", stall_req, 0);
    end
    chk("stall_c9", stall_req, 1);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("starve_we", rf_we, 1);
    chk("starve_waddr", rf_waddr, 5);
    idle();
    chk("stall_drop", stall_req, 0);
    // WAW kill, then kill on the acceptance cycle
    cyc(1, 0, 0, 0, 0, 1, 1, 3, 32'h3F80_0000);
    cyc(1, 1, 1, 3, 32'h4000_0000, 0, 0, 0, 0);
    chk("waw_wb_data", frf_wdata, 32'h4000_0000);
    idle();
    chk("waw_pop_no_we", frf_we, 0);
    idle();
    chk("waw_f3", shadow_f[3], 32'h4000_0000);
    cyc(1, 1, 1, 3, 32'h4040_0000, 1, 1, 3, 32'h3F80_0000);
    idle();
    chk("waw2_no_we", frf_we, 0);
    idle();
    chk("waw2_f3", shadow_f[3], 32'h4040_0000);
    // full queue
    for (int i = 0; i < 4; i++) cyc(1, 1, 0, 7, 32'h7, 1, 0, 5'(10 + i), 32'hA0 + i);
    cyc(1, 1, 0, 7, 32'h7, 1, 0, 14, 32'hA4);
    chk("full_ready", llu_ready, 0);
    cyc(1, 0, 0, 0, 0, 1, 0, 14, 32'hA4);
    chk("full_pop_addr", rf_waddr, 10);
    chk("full_ready_pop", llu_ready, 0);
    cyc(1, 0, 0, 0, 0, 1, 0, 14, 32'hA4);
    chk("ready_after_pop", llu_ready, 1);
    repeat (3) idle();
    chk("full_last_addr", rf_waddr, 14);
    chk("full_last_data", rf_wdata, 32'hA4);
    idle();
    // x0 handling
    cyc(1, 0, 0, 0, 0, 1, 0, 0, 32'h99);
    cyc(1, 0, 0, 0, 0, 1, 0, 9, 32'h09);
    chk("x0_no_we", rf_we, 0);
    cyc(1, 1, 0, 0, 32'hEE, 0, 0, 0, 0);
    chk("x0_wb_nonblock_we", rf_we, 1);
    chk("x0_wb_nonblock_addr", rf_waddr, 9);
    idle();
    // reset mid-operation drops queued entries
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, 7, 32'h7, 1, 0, 5'(20 + i), 32'hB0 + i);
    cyc(0, 1, 0, 7, 32'h7, 0, 0, 0, 0);
    chk("midrst_rf_we", rf_we, 0);
    chk("midrst_frf_we", frf_we, 0);
    chk("midrst_ready", llu_ready, 0);
    w0 = wr_seen;
    repeat (4) idle();
    chk("no_stale_writes", 32'(wr_seen - w0), 0);
    chk("no_x20", shadow_x[20], 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
